// File: rtl/cache_axi_master_pkg.sv
// axi_pkg: shared AXI4 encodings and the FSM state type for cache_axi_master.
// No ports. Holds the burst/size/response encodings, the line beat count,
// the state enum and a small response-decode helper.
package axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [2:0] SIZE_8B     = 3'd3;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam int         LINE_BEATS  = 2;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AR   = 3'd1,
    ST_R    = 3'd2,
    ST_AW   = 3'd3,
    ST_W0   = 3'd4,
    ST_W1   = 3'd5,
    ST_B    = 3'd6,
    ST_DONE = 3'd7
  } state_e;

  // Only DECERR marks a transaction as failed; OKAY, EXOKAY and SLVERR pass.
  function automatic logic is_decerr(input logic [1:0] resp);
    return (resp == RESP_DECERR);
  endfunction

endpackage

// File: rtl/cache_axi_master_if.sv
// cache_axi_master_if: AXI4 bus bundle between the cache master and the
// SRAM responder.
// Channels: AR (address/id/len/size/burst, valid/ready), R (data/resp/id/last,
// valid/ready), AW (as AR), W (data/strb/last, valid/ready), B (resp/id,
// valid/ready).
// Modports: master (initiator side) and slave (responder side).
interface cache_axi_master_if #(
  parameter int ADDR_W = 32
);

  logic [ADDR_W-1:0] araddr;
  logic [3:0]        arid;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              arvalid;
  logic              arready;

  logic [63:0]       rdata;
  logic [1:0]        rresp;
  logic [3:0]        rid;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  logic [ADDR_W-1:0] awaddr;
  logic [3:0]        awid;
  logic [7:0]        awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;
  logic              awvalid;
  logic              awready;

  logic [63:0]       wdata;
  logic [7:0]        wstrb;
  logic              wlast;
  logic              wvalid;
  logic              wready;

  logic [1:0]        bresp;
  logic [3:0]        bid;
  logic              bvalid;
  logic              bready;

  modport master (
    output araddr, arid, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rdata, rresp, rid, rlast, rvalid,
    output rready,
    output awaddr, awid, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bresp, bid, bvalid,
    output bready
  );

  modport slave (
    input  araddr, arid, arlen, arsize, arburst, arvalid,
    output arready,
    output rdata, rresp, rid, rlast, rvalid,
    input  rready,
    input  awaddr, awid, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bresp, bid, bvalid,
    input  bready
  );

endinterface

// File: rtl/cache_axi_master.sv
// cache_axi_master: turns one cache-side request into AXI4 traffic.
// A line request (req_line = 1) becomes a 2-beat INCR burst on a 16-byte
// aligned address; a device request becomes a 1-beat FIXED transfer at the
// unmodified address. One transaction is outstanding at a time.
// Ports:
//   clock, rst_n            clock and synchronous active-low reset
//   req_valid/req_ready     request handshake (ready only in IDLE)
//   req_write, req_line     direction and line/single select
//   req_addr, req_wdata     byte address, write data ([63:0] = beat 0)
//   req_wstrb               byte strobes for single writes
//   resp_valid              one-cycle completion pulse
//   resp_rdata, resp_err    read data and DECERR flag, held until next completion
//   axi                     AXI4 master modport
// Every AXI output comes from a flop or from the state register, so there is
// no combinational path from AXI inputs to AXI outputs.
module cache_axi_master
  import axi_pkg::*;
#(
  parameter logic [3:0] ID     = 4'd1,
  parameter int         ADDR_W = 32
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic              req_line,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [127:0]      req_wdata,
  input  logic [7:0]        req_wstrb,
  output logic              resp_valid,
  output logic [127:0]      resp_rdata,
  output logic              resp_err,
  cache_axi_master_if.master axi
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        len_q, len_d;
  logic [2:0]        size_q, size_d;
  logic [1:0]        burst_q, burst_d;
  logic              line_q, line_d;
  logic [127:0]      wbuf_q, wbuf_d;
  logic [7:0]        strb_q, strb_d;
  logic [127:0]      rbuf_q, rbuf_d;
  logic              beat_q, beat_d;
  logic              err_q, err_d;
  logic [127:0]      resp_rdata_q, resp_rdata_d;
  logic              resp_err_q, resp_err_d;

  logic              r_accept_s;
  logic              b_accept_s;

  // Beats from other IDs are dropped; only our own responses advance the FSM.
  assign r_accept_s = (state_q == ST_R) && axi.rvalid && (axi.rid == ID);
  assign b_accept_s = (state_q == ST_B) && axi.bvalid && (axi.bid == ID);

  // Next-state, request capture, read-beat assembly and error tracking.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    len_d        = len_q;
    size_d       = size_q;
    burst_d      = burst_q;
    line_d       = line_q;
    wbuf_d       = wbuf_q;
    strb_d       = strb_q;
    rbuf_d       = rbuf_q;
    beat_d       = beat_q;
    err_d        = err_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          line_d = req_line;
          wbuf_d = req_wdata;
          strb_d = req_wstrb;
          size_d = SIZE_8B;
          rbuf_d = 128'h0;
          beat_d = 1'b0;
          err_d  = 1'b0;
          if (req_line) begin
            addr_d  = {req_addr[ADDR_W-1:4], 4'b0000};
            len_d   = 8'(LINE_BEATS - 1);
            burst_d = BURST_INCR;
          end else begin
            addr_d  = req_addr;
            len_d   = 8'd0;
            burst_d = BURST_FIXED;
          end
          if (req_write) begin
            state_d = ST_AW;
          end else begin
            state_d = ST_AR;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_AR: begin
        if (axi.arready) begin
          state_d = ST_R;
        end else begin
          state_d = ST_AR;
        end
      end
      ST_R: begin
        if (r_accept_s) begin
          if (beat_q == 1'b0) begin
            rbuf_d[63:0] = axi.rdata;
          end else begin
            rbuf_d[127:64] = axi.rdata;
          end
          beat_d = 1'b1;
          if (is_decerr(axi.rresp)) begin
            err_d = 1'b1;
          end else begin
            err_d = err_q;
          end
          // A single read completes on its only beat whatever rlast says.
          if (axi.rlast || !line_q) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_R;
          end
        end else begin
          state_d = ST_R;
        end
      end
      ST_AW: begin
        if (axi.awready) begin
          state_d = ST_W0;
        end else begin
          state_d = ST_AW;
        end
      end
      ST_W0: begin
        if (axi.wready) begin
          if (line_q) begin
            state_d = ST_W1;
          end else begin
            state_d = ST_B;
          end
        end else begin
          state_d = ST_W0;
        end
      end
      ST_W1: begin
        if (axi.wready) begin
          state_d = ST_B;
        end else begin
          state_d = ST_W1;
        end
      end
      ST_B: begin
        if (b_accept_s) begin
          if (is_decerr(axi.bresp)) begin
            err_d = 1'b1;
          end else begin
            err_d = err_q;
          end
          state_d = ST_DONE;
        end else begin
          state_d = ST_B;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Results are published on entry to DONE and then held until the next one.
    if ((state_d == ST_DONE) && (state_q != ST_DONE)) begin
      resp_rdata_d = rbuf_d;
      resp_err_d   = err_d;
    end else begin
      resp_rdata_d = resp_rdata_q;
      resp_err_d   = resp_err_q;
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      len_q        <= 8'd0;
      size_q       <= 3'd0;
      burst_q      <= 2'b00;
      line_q       <= 1'b0;
      wbuf_q       <= 128'h0;
      strb_q       <= 8'h00;
      rbuf_q       <= 128'h0;
      beat_q       <= 1'b0;
      err_q        <= 1'b0;
      resp_rdata_q <= 128'h0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      len_q        <= len_d;
      size_q       <= size_d;
      burst_q      <= burst_d;
      line_q       <= line_d;
      wbuf_q       <= wbuf_d;
      strb_q       <= strb_d;
      rbuf_q       <= rbuf_d;
      beat_q       <= beat_d;
      err_q        <= err_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = (state_q == ST_DONE);
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

  // AR and AW share one set of captured fields; only one is ever valid.
  assign axi.araddr  = addr_q;
  assign axi.arid    = ID;
  assign axi.arlen   = len_q;
  assign axi.arsize  = size_q;
  assign axi.arburst = burst_q;
  assign axi.arvalid = (state_q == ST_AR);
  assign axi.rready  = (state_q == ST_R);

  assign axi.awaddr  = addr_q;
  assign axi.awid    = ID;
  assign axi.awlen   = len_q;
  assign axi.awsize  = size_q;
  assign axi.awburst = burst_q;
  assign axi.awvalid = (state_q == ST_AW);

  assign axi.wvalid  = (state_q == ST_W0) || (state_q == ST_W1);
  assign axi.wdata   = (state_q == ST_W1) ? wbuf_q[127:64] : wbuf_q[63:0];
  assign axi.wstrb   = (state_q == ST_W1) ? 8'hFF :
                       (state_q == ST_W0) ? (line_q ? 8'hFF : strb_q) : 8'h00;
  assign axi.wlast   = ((state_q == ST_W0) && !line_q) || (state_q == ST_W1);
  assign axi.bready  = (state_q == ST_B);

endmodule

// File: tb/tb_cache_axi_master.sv
// tb_cache_axi_master: directed scoreboard bench for cache_axi_master.
// Stimulus pushes expected AR/AW descriptors, W beats and completions into
// queues; one negedge monitor pops and compares on every handshake/pulse.
module tb_cache_axi_master;
  import axi_pkg::*;

  logic          clock = 1'b0;
  logic          rst_n;
  logic          req_valid, req_ready, req_write, req_line;
  logic [31:0]   req_addr;
  logic [127:0]  req_wdata;
  logic [7:0]    req_wstrb;
  logic          resp_valid, resp_err;
  logic [127:0]  resp_rdata;

  always #5 clock = ~clock;

  cache_axi_master_if #(.ADDR_W(32)) axi ();

  cache_axi_master #(.ID(4'd1), .ADDR_W(32)) dut (
    .clock      (clock),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_line   (req_line),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_wstrb  (req_wstrb),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .axi        (axi.master)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [1:0]  burst;
  } ax_t;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  strb;
    logic        last;
  } w_t;

  typedef struct packed {
    logic [127:0] rdata;
    logic         err;
  } rsp_t;

  ax_t  exp_ar[$];
  ax_t  exp_aw[$];
  w_t   exp_w[$];
  rsp_t exp_rsp[$];

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic empty_pop(input string name);
    n_checks++;
    n_fails++;
    $display("FAIL %s: DUT produced an item with no expected entry queued", name);
  endtask

  // Scoreboard monitor: compares every AXI handshake and completion pulse.
  logic aw_seen   = 1'b0;
  logic prev_resp = 1'b0;
  always @(negedge clock) begin
    ax_t  ea;
    w_t   ew;
    rsp_t er;
    if (!rst_n) begin
      aw_seen   <= 1'b0;
      prev_resp <= 1'b0;
    end else begin
      if (axi.arvalid && axi.arready) begin
        if (exp_ar.size() == 0) begin
          empty_pop("ar_unexpected");
        end else begin
          ea = exp_ar.pop_front();
          check("araddr", axi.araddr, ea.addr);
          check("arlen", axi.arlen, ea.len);
          check("arburst", axi.arburst, ea.burst);
          check("arsize", axi.arsize, SIZE_8B);
          check("arid", axi.arid, 4'd1);
        end
      end
      if (axi.awvalid && axi.awready) begin
        aw_seen <= 1'b1;
        if (exp_aw.size() == 0) begin
          empty_pop("aw_unexpected");
        end else begin
          ea = exp_aw.pop_front();
          check("awaddr", axi.awaddr, ea.addr);
          check("awlen", axi.awlen, ea.len);
          check("awburst", axi.awburst, ea.burst);
          check("awsize", axi.awsize, SIZE_8B);
          check("awid", axi.awid, 4'd1);
        end
      end
      if (axi.wvalid && axi.wready) begin
        check("w_after_aw", aw_seen, 1'b1);
        check("w_not_with_aw", axi.awvalid, 1'b0);
        if (axi.wlast) aw_seen <= 1'b0;
        if (exp_w.size() == 0) begin
          empty_pop("w_unexpected");
        end else begin
          ew = exp_w.pop_front();
          check("wdata", axi.wdata, ew.data);
          check("wstrb", axi.wstrb, ew.strb);
          check("wlast", axi.wlast, ew.last);
        end
      end
      if (resp_valid) begin
        check("resp_one_cycle", prev_resp, 1'b0);
        if (exp_rsp.size() == 0) begin
          empty_pop("resp_unexpected");
        end else begin
          er = exp_rsp.pop_front();
          check("resp_rdata", resp_rdata, er.rdata);
          check("resp_err", resp_err, er.err);
        end
      end
      prev_resp <= resp_valid;
    end
  end

  // Waits (bounded) for a handshake, then steps past the edge that takes it.
  task automatic wait_sig(input int which, input string name);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      case (which)
        0:       hit = axi.arvalid && axi.arready;
        1:       hit = axi.awvalid && axi.awready;
        2:       hit = axi.wvalid && axi.wready;
        3:       hit = resp_valid;
        default: hit = 1'b0;
      endcase
      if (!hit) @(negedge clock);
    end
    check(name, hit, 1'b1);
    if (hit) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Issues one request; called just after a rising edge, returns at negedge.
  task automatic do_req(input logic w, input logic line, input logic [31:0] addr,
                        input logic [127:0] wd, input logic [7:0] strb);
    req_write = w;
    req_line  = line;
    req_addr  = addr;
    req_wdata = wd;
    req_wstrb = strb;
    req_valid = 1'b1;
    @(negedge clock);
    check("req_ready_idle", req_ready, 1'b1);
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    @(negedge clock);
    check("req_ready_busy", req_ready, 1'b0);
    if (w) check("awvalid_next_cycle", axi.awvalid, 1'b1);
    else   check("arvalid_next_cycle", axi.arvalid, 1'b1);
  endtask

  task automatic send_r(input logic [63:0] d, input logic [1:0] resp,
                        input logic [3:0] id, input logic last);
    axi.rdata  = d;
    axi.rresp  = resp;
    axi.rid    = id;
    axi.rlast  = last;
    axi.rvalid = 1'b1;
    @(negedge clock);
    check("rready", axi.rready, 1'b1);
    @(posedge clock);
    #1;
    axi.rvalid = 1'b0;
    axi.rlast  = 1'b0;
  endtask

  task automatic send_b(input logic [1:0] resp, input logic [3:0] id);
    bit got;
    got        = 1'b0;
    axi.bresp  = resp;
    axi.bid    = id;
    axi.bvalid = 1'b1;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clock);
      got = axi.bready;
    end
    check("bready_seen", got, 1'b1);
    @(posedge clock);
    #1;
    axi.bvalid = 1'b0;
  endtask

  task automatic idle_gap();
    repeat (2) @(posedge clock);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_line = 1'b0;
    req_addr = 32'h0; req_wdata = 128'h0; req_wstrb = 8'h00;
    axi.arready = 1'b1; axi.awready = 1'b1; axi.wready = 1'b1;
    axi.rvalid = 1'b0; axi.rdata = 64'h0; axi.rresp = 2'b00; axi.rid = 4'd0; axi.rlast = 1'b0;
    axi.bvalid = 1'b0; axi.bresp = 2'b00; axi.bid = 4'd0;

    // Reset state.
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_arvalid", axi.arvalid, 1'b0);
    check("rst_awvalid", axi.awvalid, 1'b0);
    check("rst_wvalid", axi.wvalid, 1'b0);
    check("rst_rready", axi.rready, 1'b0);
    check("rst_bready", axi.bready, 1'b0);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_resp_rdata", resp_rdata, 128'h0);
    check("rst_resp_err", resp_err, 1'b0);
    check("rst_wlast", axi.wlast, 1'b0);
    check("rst_araddr", axi.araddr, 32'h0);
    check("rst_arlen", axi.arlen, 8'h0);
    check("rst_wdata", axi.wdata, 64'h0);
    @(posedge clock);
    #1;
    rst_n = 1'b1;
    idle_gap();

    // Line read, zero-wait responder.
    exp_ar.push_back('{32'h8000_0020, 8'd1, BURST_INCR});
    exp_rsp.push_back('{{64'h2222, 64'h1111}, 1'b0});
    do_req(1'b0, 1'b1, 32'h8000_0024, 128'h0, 8'h00);
    wait_sig(0, "t1_ar_hs");
    send_r(64'h1111, 2'b00, 4'd1, 1'b0);
    send_r(64'h2222, 2'b00, 4'd1, 1'b1);
    @(negedge clock);
    check("t1_resp_after_rlast", resp_valid, 1'b1);
    idle_gap();

    // Line write, bresp = EXOKAY.
    exp_aw.push_back('{32'h8000_0010, 8'd1, BURST_INCR});
    exp_w.push_back('{64'hAAAA, 8'hFF, 1'b0});
    exp_w.push_back('{64'hBBBB, 8'hFF, 1'b1});
    exp_rsp.push_back('{128'h0, 1'b0});
    do_req(1'b1, 1'b1, 32'h8000_0010, {64'hBBBB, 64'hAAAA}, 8'h00);
    wait_sig(1, "t2_aw_hs");
    wait_sig(2, "t2_w0_hs");
    wait_sig(2, "t2_w1_hs");
    send_b(2'b01, 4'd1);
    wait_sig(3, "t2_resp");
    idle_gap();

    // Single write with partial strobes.
    exp_aw.push_back('{32'hA000_03F8, 8'd0, BURST_FIXED});
    exp_w.push_back('{64'h0123_4567_89AB_CDEF, 8'h0F, 1'b1});
    exp_rsp.push_back('{128'h0, 1'b0});
    do_req(1'b1, 1'b0, 32'hA000_03F8, {64'hFFFF_0000_FFFF_0000, 64'h0123_4567_89AB_CDEF}, 8'h0F);
    wait_sig(1, "t3_aw_hs");
    wait_sig(2, "t3_w_hs");
    send_b(2'b00, 4'd1);
    wait_sig(3, "t3_resp");
    idle_gap();

    // Single read returning DECERR.
    exp_ar.push_back('{32'hA000_0048, 8'd0, BURST_FIXED});
    exp_rsp.push_back('{{64'h0, 64'hDEAD}, 1'b1});
    do_req(1'b0, 1'b0, 32'hA000_0048, 128'h0, 8'h00);
    wait_sig(0, "t4_ar_hs");
    send_r(64'hDEAD, 2'b11, 4'd1, 1'b1);
    wait_sig(3, "t4_resp");
    idle_gap();

    // AR backpressure, then a foreign-ID beat that must be ignored.
    axi.arready = 1'b0;
    exp_ar.push_back('{32'h8000_0100, 8'd1, BURST_INCR});
    exp_rsp.push_back('{{64'h4444, 64'h3333}, 1'b0});
    do_req(1'b0, 1'b1, 32'h8000_0108, 128'h0, 8'h00);
    repeat (5) begin
      @(negedge clock);
      check("t5_arvalid_stall", axi.arvalid, 1'b1);
      check("t5_araddr_stall", axi.araddr, 32'h8000_0100);
    end
    @(posedge clock);
    #1;
    axi.arready = 1'b1;
    wait_sig(0, "t5_ar_hs");
    send_r(64'h9999, 2'b11, 4'd2, 1'b0);
    send_r(64'h3333, 2'b00, 4'd1, 1'b0);
    send_r(64'h4444, 2'b10, 4'd1, 1'b1);
    wait_sig(3, "t5_resp");
    idle_gap();

    // Reset while in W1, then a normal read.
    axi.wready = 1'b0;
    exp_aw.push_back('{32'h8000_0030, 8'd1, BURST_INCR});
    exp_w.push_back('{64'hC0C0, 8'hFF, 1'b0});
    do_req(1'b1, 1'b1, 32'h8000_003C, {64'hD0D0, 64'hC0C0}, 8'h00);
    wait_sig(1, "t6_aw_hs");
    @(negedge clock);
    check("t6_w0_valid", axi.wvalid, 1'b1);
    @(posedge clock);
    #1;
    axi.wready = 1'b1;
    wait_sig(2, "t6_w0_hs");
    axi.wready = 1'b0;
    @(negedge clock);
    check("t6_w1_valid", axi.wvalid, 1'b1);
    check("t6_w1_wlast", axi.wlast, 1'b1);
    check("t6_w1_wdata", axi.wdata, 64'hD0D0);
    @(posedge clock);
    #1;
    rst_n = 1'b0;
    @(posedge clock);
    #1;
    rst_n = 1'b1;
    @(negedge clock);
    check("t6_rst_arvalid", axi.arvalid, 1'b0);
    check("t6_rst_awvalid", axi.awvalid, 1'b0);
    check("t6_rst_wvalid", axi.wvalid, 1'b0);
    check("t6_rst_rready", axi.rready, 1'b0);
    check("t6_rst_bready", axi.bready, 1'b0);
    check("t6_rst_resp_valid", resp_valid, 1'b0);
    check("t6_rst_req_ready", req_ready, 1'b1);
    @(posedge clock);
    #1;
    axi.wready = 1'b1;
    exp_ar.push_back('{32'h8000_0040, 8'd1, BURST_INCR});
    exp_rsp.push_back('{{64'h6666, 64'h5555}, 1'b0});
    do_req(1'b0, 1'b1, 32'h8000_0040, 128'h0, 8'h00);
    wait_sig(0, "t7_ar_hs");
    send_r(64'h5555, 2'b00, 4'd1, 1'b0);
    send_r(64'h6666, 2'b00, 4'd1, 1'b1);
    wait_sig(3, "t7_resp");
    idle_gap();

    check("drain_ar", exp_ar.size(), 0);
    check("drain_aw", exp_aw.size(), 0);
    check("drain_w", exp_w.size(), 0);
    check("drain_rsp", exp_rsp.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/cache_axi_master.md
# cache_axi_master

- AXI4 initiator that turns one cache-side transaction into AXI4 channel traffic for the simulated SRAM responder.
- A request is either a 16-byte cache-line refill or writeback, sent as a 2-beat INCR burst, or a single uncached device access, sent as a 1-beat FIXED transfer.
- Only one transaction is outstanding at a time.
- Sits between the D-cache/LSU miss path and the system AXI bus.

## Interface
Parameters:
- ID, 4'd1: value driven on arid/awid; responses are accepted only when rid/bid equal it.
- ADDR_W, 32: address width.

Ports:
- clock  in  1  clock.
- rst_n  in  1  synchronous, active-low reset.
- req_valid / req_ready  in/out  1/1  request handshake; req_ready is high only in IDLE.
- req_write  in  1  1 = write, 0 = read.
- req_line  in  1  1 = 16-byte line burst, 0 = single device access.
- req_addr  in  32  byte address.
- req_wdata  in  128  write data; [63:0] is beat 0, [127:64] is beat 1.
- req_wstrb  in  8  byte strobes, used for single writes only.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  128  read data; for single reads [127:64] = 0.
- resp_err  out  1  set when rresp or bresp = 2'b11 was seen during the transaction.
- araddr/arid/arlen/arsize/arburst, arvalid  out  32/4/8/3/2, 1; arready  in  1.
- rdata/rresp/rid/rlast, rvalid  in  64/2/4/1, 1; rready  out  1.
- awaddr/awid/awlen/awsize/awburst, awvalid  out  32/4/8/3/2, 1; awready  in  1.
- wdata/wstrb/wlast, wvalid  out  64/8/1, 1; wready  in  1.
- bresp/bid, bvalid  in  2/4, 1; bready  out  1.

## Operation
- FSM states: IDLE, AR, R, AW, W0, W1, B, DONE.
- IDLE: if req_valid, capture the request.
  - Read goes to AR; write goes to AW.
- Line transfer fields: addr = {req_addr[31:4],4'b0}, len = 1, size = 3, burst = 2'b01.
- Single transfer fields: addr = req_addr unmodified, len = 0, size = 3, burst = 2'b00.
- AR: arvalid = 1, held with stable fields until arready. Then go to R.
- R: rready = 1. A beat is accepted only when rvalid && rid == ID; other beats are ignored.
  - Beat 0 goes to rdata_buf[63:0], beat 1 to [127:64].
  - Leave to DONE on an accepted beat with rlast = 1.
  - For a single read, leave to DONE on the first accepted beat regardless of rlast.
- AW: awvalid = 1 until awready. Then go to W0. W is never driven in the same cycle as AW.
- W0: wvalid = 1, wdata = buf[63:0].
  - Line: wstrb = 8'hFF, wlast = 0.
  - Single: wstrb = req_wstrb, wlast = 1.
  - On wready: line goes to W1, single goes to B.
- W1: wdata = buf[127:64], wstrb = 8'hFF, wlast = 1. On wready go to B.
- B: bready = 1. On bvalid && bid == ID go to DONE.
- DONE: resp_valid = 1 for one cycle, then IDLE.
- Response codes: rresp/bresp values 00, 01 and 10 count as success; only 11 sets resp_err.
  - The error flag is sticky across the beats of one transaction and cleared on request accept.

## Timing
- Reset: state = IDLE, req_ready = 1.
  - All valid/ready outputs = 0: arvalid, awvalid, wvalid, rready, bready, resp_valid.
  - resp_rdata = 0, resp_err = 0, wlast = 0.
  - All address/len/size/burst/data outputs = 0.
- All outputs are registered or decoded from state. There is no combinational path from AXI inputs to AXI outputs.
- Reset mid-transaction aborts immediately to IDLE. The AXI handshake is abandoned with no recovery.
- Request accepted in cycle t → arvalid/awvalid high in cycle t+1.
- Line read with zero-wait responder: resp_valid is high one cycle after the rlast beat.
- resp_rdata and resp_err hold their value from DONE until the next DONE.
- A req_valid in DONE or any busy state is not accepted.
- Stalls: arready, awready or wready held low keeps the corresponding valid and payload stable indefinitely.
- A beat arriving with rvalid while not in R is ignored.

## Structure
- Shared package axi_pkg holds:
  - BURST_FIXED = 2'b00, BURST_INCR = 2'b01.
  - SIZE_8B = 3'd3.
  - RESP_DECERR = 2'b11.
  - LINE_BEATS = 2.
  - The FSM state enum.
- Single module with no sub-module; the FSM and data buffers are small enough to keep flat.

## Test plan
- Line read at 0x8000_0024, responder returns 0x1111 then 0x2222 with rlast on the second beat.
  - araddr = 0x8000_0020, arlen = 1, arburst = 01.
  - resp_rdata = {0x2222, 0x1111}, one-cycle resp_valid, resp_err = 0.
- Line write at 0x8000_0010, wdata = {0xBBBB, 0xAAAA}.
  - AW handshake strictly before W.
  - Beats 0xAAAA (wlast = 0) then 0xBBBB (wlast = 1), wstrb = 0xFF.
  - Completion on bvalid with bresp = 01, resp_err = 0.
- Single write at 0xA000_03F8, wstrb = 0x0F.
  - awburst = 00, awlen = 0, one beat with wlast = 1 and wstrb = 0x0F.
- Single read at 0xA000_0048, responder returns 0xDEAD with rresp = 11.
  - resp_rdata = {64'h0, 0xDEAD}, resp_err = 1.
- Backpressure and ID filtering:
  - arready low for 5 cycles: arvalid and araddr stay stable throughout.
  - A beat with rid = 2 is ignored, and the following rid = 1 beat is accepted.
- Reset asserted in W1: next cycle all valids are 0 and req_ready = 1.
  - A new read then completes normally.
